mem_arbiter_rr: RTL

//  N-port arbiter for the single shared memory port. It sits between the I-cache, the D-cache and
//  any further refill/writeback clients, and the main-memory model.

---
 rtl/brisc_pkg.sv | 16 +
 rtl/ff.sv | 27 ++
 rtl/mem_arbiter_rr_pick.sv | 41 ++++
 rtl/mem_arbiter_rr.sv | 133 +++++++++++++
 4 files changed

// File: rtl/brisc_pkg.sv
// -----------------------------------------------------------------------------
// brisc_pkg: shared widths and arbiter enums for the memory subsystem. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package brisc_pkg;

    localparam int ADDRESS_WIDTH    = 32;
    localparam int CACHE_LINE_WIDTH = 128;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

endpackage

`default_nettype wire

// File: rtl/ff.sv
// -----------------------------------------------------------------------------
// ff: enabled register with synchronous active-low reset. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_o <= RESET_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick: first set request at or after ptr, wrapping modulo N. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          valid,
    output logic [PW-1:0] idx
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW-1:0]  off;
    logic [PW:0]    sum;

    always_comb begin
        dbl   = {req, req};
        rot   = dbl[ptr +: N];
        valid = |req;
        off   = '0;
        // Descending scan so the lowest rotated position is the one kept.
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = PW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PW + 1)'(N)) begin
            sum = sum - (PW + 1)'(N);
        end
        idx = sum[PW-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr: N-port shared memory arbiter, fixed or round-robin. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_arbiter_rr
    import brisc_pkg::*;
#(
    parameter int        N_PORTS = 2,
    parameter arb_mode_e MODE    = ARB_RR,
    parameter int        ADDR_W  = ADDRESS_WIDTH,
    parameter int        LINE_W  = CACHE_LINE_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS-1:0]        write,
    input  logic [N_PORTS*ADDR_W-1:0] addr,
    input  logic [N_PORTS*LINE_W-1:0] wdata,
    output logic [N_PORTS-1:0]        grant,
    output logic                      mem_req,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LINE_W-1:0]         mem_data,
    input  logic                      mem_ready
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    arb_state_e    state_q;
    arb_state_e    state_d;
    logic          state_raw_q;
    logic [PW-1:0] owner_q;
    logic [PW-1:0] owner_d;
    logic          owner_en;
    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;
    logic          rr_ptr_en;
    logic [PW-1:0] pick_ptr;
    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic          owner_req;
    logic          busy;

    ff #(.WIDTH(1), .RESET_VAL(1'b0)) u_state_ff (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (1'b1),
        .d_i     (state_d),
        .q_o     (state_raw_q)
    );

    ff #(.WIDTH(PW), .RESET_VAL('0)) u_owner_ff (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (owner_en),
        .d_i     (owner_d),
        .q_o     (owner_q)
    );

    ff #(.WIDTH(PW), .RESET_VAL('0)) u_rr_ptr_ff (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (rr_ptr_en),
        .d_i     (rr_ptr_d),
        .q_o     (rr_ptr_q)
    );

    assign state_q  = arb_state_e'(state_raw_q);
    assign busy     = (state_q == ARB_BUSY);
    assign pick_ptr = (MODE == ARB_RR) ? rr_ptr_q : '0;

    rr_pick #(.N(N_PORTS), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        owner_req = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (owner_q == PW'(i)) begin
                owner_req = req[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        owner_en  = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        rr_ptr_en = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d  = ARB_BUSY;
                    owner_d  = pick_idx;
                    owner_en = 1'b1;
                end
            end
            ARB_BUSY: begin
                // Completion and abort both release the port and advance the pointer.
                if (mem_ready || !owner_req) begin
                    state_d   = ARB_IDLE;
                    rr_ptr_en = (MODE == ARB_RR);
                    rr_ptr_d  = (owner_q == PW'(N_PORTS - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        grant     = '0;
        mem_req   = busy;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (busy && owner_q == PW'(i)) begin
                grant[i]  = 1'b1;
                mem_write = write[i];
                mem_addr  = addr[i*ADDR_W +: ADDR_W];
                mem_data  = wdata[i*LINE_W +: LINE_W];
            end
        end
    end

endmodule

`default_nettype wire
